// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential single-neuron multiply-accumulate engine.
// It walks the weight memory one NUM_DATA-wide window at a time. Each window
// is multiplied with a streamed activation chunk, and the products are summed
// into a signed accumulator. When all chunks are in, the bias is added and
// ReLU is optionally applied. The result is then handed downstream over a
// valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin one evaluation (honoured in IDLE only)
//   base_addr/bias/relu_en per-evaluation setup, sampled on start
//   in_valid/in_ready     activation chunk handshake, in_data lanes [i*DW +: DW]
//   w_addr/w_data         weight memory start address / combinational window
//   out_valid/out_ready   result handshake, out_data signed result
//   busy                  high whenever the engine is not IDLE
module neuron_mac_seq #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_DATA   = 4,
    parameter int unsigned NUM_INPUTS = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH + $clog2(NUM_INPUTS) + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [$clog2(DEPTH)-1:0]         base_addr,
    input  logic [ACC_WIDTH-1:0]             bias,
    input  logic                             relu_en,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_DATA*DATA_WIDTH-1:0]   in_data,
    output logic [$clog2(DEPTH)-1:0]         w_addr,
    input  logic [NUM_DATA*DATA_WIDTH-1:0]   w_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_WIDTH-1:0]             out_data,
    output logic                             busy
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam int unsigned PROD_W     = 2*DATA_WIDTH;
    localparam int unsigned NUM_CHUNKS = NUM_INPUTS / NUM_DATA;
    localparam int unsigned CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_BIAS  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [AW-1:0]               w_addr_q, w_addr_d;
    logic [ACC_WIDTH-1:0]        out_data_q, out_data_d;
    logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
    logic                        relu_q, relu_d;

    logic signed [ACC_WIDTH-1:0]  chunk_sum_c;
    logic signed [ACC_WIDTH-1:0]  biased_c;
    logic signed [DATA_WIDTH-1:0] lane_a_c, lane_w_c;
    logic signed [PROD_W-1:0]     lane_p_c;
    logic                         in_hs_c;

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign w_addr    = w_addr_q;
    assign out_data  = out_data_q;
    assign in_hs_c   = in_valid & in_ready;

    // Full-precision dot product of the activation chunk and the weight window
    always_comb begin
        chunk_sum_c = '0;
        lane_a_c    = '0;
        lane_w_c    = '0;
        lane_p_c    = '0;
        for (int i = 0; i < int'(NUM_DATA); i++) begin
            lane_a_c    = $signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
            lane_w_c    = $signed(w_data[i*DATA_WIDTH +: DATA_WIDTH]);
            lane_p_c    = PROD_W'(lane_a_c) * PROD_W'(lane_w_c);
            chunk_sum_c = chunk_sum_c + ACC_WIDTH'(lane_p_c);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        w_addr_d   = w_addr_q;
        out_data_d = out_data_q;
        bias_d     = bias_q;
        relu_d     = relu_q;
        biased_c   = acc_q + bias_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_addr_d = base_addr;
                    bias_d   = $signed(bias);
                    relu_d   = relu_en;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_hs_c) begin
                    acc_d    = acc_q + chunk_sum_c;
                    cnt_d    = cnt_q + CNT_W'(1);
                    w_addr_d = w_addr_q + AW'(NUM_DATA);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_BIAS;
                    end
                end
            end
            S_BIAS: begin
                // Result register is loaded here so it is stable for all of OUT
                acc_d      = biased_c;
                out_data_d = (relu_q && biased_c[ACC_WIDTH-1]) ? '0 : biased_c;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            w_addr_q   <= '0;
            out_data_q <= '0;
            bias_q     <= '0;
            relu_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            w_addr_q   <= w_addr_d;
            out_data_q <= out_data_d;
            bias_q     <= bias_d;
            relu_q     <= relu_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq: self-checking bench for neuron_mac_seq.
// A behavioural weight memory drives w_data from w_addr. Expected results go
// into a scoreboard queue when each evaluation is started. They are taken out
// again when the result handshake completes.
module tb_neuron_mac_seq;

    localparam int unsigned DW    = 8;
    localparam int unsigned ND    = 4;
    localparam int unsigned NI    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned ACCW  = 20;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [ACCW-1:0]      bias;
    logic                 relu_en;
    logic                 in_valid;
    logic                 in_ready;
    logic [ND*DW-1:0]     in_data;
    logic [AW-1:0]        w_addr;
    logic [ND*DW-1:0]     w_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACCW-1:0]      out_data;
    logic                 busy;

    logic [DW-1:0] wmem [DEPTH];
    int            act [NI];
    int            sb_q [$];
    int            n_checks;
    int            n_errors;

    neuron_mac_seq #(
        .DATA_WIDTH (DW),
        .NUM_DATA   (ND),
        .NUM_INPUTS (NI),
        .DEPTH      (DEPTH),
        .ACC_WIDTH  (ACCW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .bias      (bias),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational weight window, wrapping around the memory
    always_comb begin
        w_data = '0;
        for (int i = 0; i < int'(ND); i++) begin
            w_data[i*DW +: DW] = wmem[AW'(w_addr + AW'(i))];
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fill_w(input int v);
        for (int i = 0; i < int'(DEPTH); i++) wmem[i] = DW'(v);
    endtask

    task automatic fill_act(input int v);
        for (int j = 0; j < int'(NI); j++) act[j] = v;
    endtask

    task automatic drive_chunk(input int c);
        for (int i = 0; i < int'(ND); i++) in_data[i*DW +: DW] = DW'(act[c*ND + i]);
    endtask

    // One full evaluation; called at a negedge with the engine in IDLE
    task automatic run_neuron(input logic [AW-1:0] base, input int bias_v, input bit relu,
                              input bit gaps, input int hold, input bit poke);
        int exp;
        int n;
        exp = bias_v;
        for (int j = 0; j < int'(NI); j++)
            exp += act[j] * int'($signed(wmem[AW'(base + AW'(j))]));
        if (relu && exp < 0) exp = 0;
        sb_q.push_back(exp);

        start     = 1'b1;
        base_addr = base;
        bias      = ACCW'(bias_v);
        relu_en   = relu;
        tick();
        start     = 1'b0;
        base_addr = ~base;
        bias      = ACCW'(12345);
        relu_en   = ~relu;
        chk("busy_accum", int'(busy), 1);

        for (int c = 0; c < int'(NI/ND); c++) begin
            if (gaps) begin
                in_valid = 1'b0;
                drive_chunk(c);
                tick();
                chk("w_addr_gap", int'(w_addr), int'(AW'(base + AW'(c*ND))));
            end
            chk("in_ready_accum", int'(in_ready), 1);
            chk("w_addr_seq", int'(w_addr), int'(AW'(base + AW'(c*ND))));
            in_valid = 1'b1;
            drive_chunk(c);
            tick();
            in_valid = 1'b0;
        end

        chk("lat_bias_valid", int'(out_valid), 0);
        chk("lat_bias_ready", int'(in_ready), 0);
        tick();
        chk("lat_out_valid", int'(out_valid), 1);

        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            if (poke && h == 1) begin
                start     = 1'b1;
                base_addr = AW'(12);
                bias      = ACCW'(777);
            end
            tick();
            start = 1'b0;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'($signed(out_data)), exp);
            chk("hold_in_ready", int'(in_ready), 0);
            chk("hold_busy", int'(busy), 1);
        end

        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 0, 1);
        end else if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            chk("result", int'($signed(out_data)), sb_q.pop_front());
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("idle_valid", int'(out_valid), 0);
            chk("idle_busy", int'(busy), 0);
            chk("w_addr_final", int'(w_addr), int'(AW'(base + AW'(NI))));
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        bias      = '0;
        relu_en   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        fill_w(0);
        fill_act(0);
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_w_addr", int'(w_addr), 0);
        chk("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;
        tick();

        // 1: unit weights, ramp inputs -> 36
        fill_w(1);
        for (int j = 0; j < int'(NI); j++) act[j] = j + 1;
        run_neuron(AW'(0), 0, 1'b0, 1'b0, 0, 1'b0);

        // 2: negative sum, with and without ReLU
        fill_w(-1);
        fill_act(3);
        run_neuron(AW'(0), 4, 1'b0, 1'b0, 0, 1'b0);
        run_neuron(AW'(0), 4, 1'b1, 1'b0, 0, 1'b0);

        // 3: extreme operands -> 131071
        fill_w(-128);
        fill_act(-128);
        run_neuron(AW'(0), -1, 1'b0, 1'b0, 0, 1'b0);

        // 4: gapped input, output backpressure, start ignored in OUT
        for (int i = 0; i < int'(DEPTH); i++) wmem[i] = DW'(i - 5);
        for (int j = 0; j < int'(NI); j++) act[j] = 7 - 3*j;
        run_neuron(AW'(4), -9, 1'b0, 1'b1, 5, 1'b1);
        chk("ignored_start_idle", int'(busy), 0);

        // 5: reset mid-ACCUM, then a clean evaluation from base 8
        start     = 1'b1;
        base_addr = AW'(0);
        bias      = ACCW'(100);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        drive_chunk(0);
        tick();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_w_addr", int'(w_addr), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 8; i < 16; i++) wmem[i] = DW'(2*i - 20);
        for (int j = 0; j < int'(NI); j++) act[j] = j - 3;
        run_neuron(AW'(8), 5, 1'b0, 1'b0, 0, 1'b0);

        // 6: back-to-back random evaluations
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'(DEPTH); i++) wmem[i] = DW'($urandom_range(0, 255));
            for (int j = 0; j < int'(NI); j++) act[j] = int'($urandom_range(0, 255)) - 128;
            run_neuron(AW'(4*r), int'($urandom_range(0, 2000)) - 1000, bit'(r % 2), 1'b0, 0, 1'b0);
        end

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
